// File: rtl/fetch_cycle_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// master = fetch side, slave = memory side.
interface fetch_cycle_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req, imem_addr,
        input  imem_ready, imem_rvalid, imem_rdata
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ready, imem_rvalid, imem_rdata
    );
endinterface

// File: rtl/fetch_cycle.sv
// RV32I fetch stage with IF/ID register: one outstanding imem request,
// redirect/stall/flush handling and a 1-entry hold buffer for stalled responses.
module fetch_cycle #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 StallF,
    input  logic                 StallD,
    input  logic                 FlushD,
    input  logic                 PCSrcE,
    input  logic [31:0]          PCTargetE,
    fetch_cycle_if.master        imem,
    output logic [31:0]          InstrD,
    output logic [31:0]          PCD,
    output logic [31:0]          PCPlus4D,
    output logic                 ValidD
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DROP} state_e;

    state_e      state_q, state_d;
    logic [31:0] pcf_q, pcf_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcd_q, pcd_d;
    logic [31:0] pcp4_q, pcp4_d;
    logic        valid_q, valid_d;

    logic        req;
    logic        accept;
    logic        resp;

    // req is built only from state, hold occupancy and hazard inputs, never from rvalid/rdata
    assign req    = (state_q == FETCH) && !StallF && !hold_valid_q && !PCSrcE;
    assign accept = req && imem.imem_ready;
    assign resp   = (state_q == WAIT) && imem.imem_rvalid && !PCSrcE && !FlushD;

    assign imem.imem_req  = req;
    assign imem.imem_addr = pcf_q;
    assign InstrD         = instr_q;
    assign PCD            = pcd_q;
    assign PCPlus4D       = pcp4_q;
    assign ValidD         = valid_q;

    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        req_pc_d     = req_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        hold_pc_d    = hold_pc_q;
        instr_d      = instr_q;
        pcd_d        = pcd_q;
        pcp4_d       = pcp4_q;
        valid_d      = 1'b0;

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (accept) state_d = WAIT;
            WAIT:    if (imem.imem_rvalid) state_d = FETCH;
                     else if (PCSrcE) state_d = DROP;
            DROP:    if (imem.imem_rvalid) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            req_pc_d = pcf_q;
            pcf_d    = pcf_q + 32'd4;
        end
        if (PCSrcE) pcf_d = PCTargetE;

        if (FlushD) begin
            instr_d      = NOP_INSTR;
            pcd_d        = '0;
            pcp4_d       = '0;
            hold_valid_d = 1'b0;
        end else if (StallD) begin
            valid_d = valid_q;
            if (resp) begin
                hold_valid_d = 1'b1;
                hold_instr_d = imem.imem_rdata;
                hold_pc_d    = req_pc_q;
            end
        end else if (hold_valid_q && !PCSrcE) begin
            instr_d      = hold_instr_q;
            pcd_d        = hold_pc_q;
            pcp4_d       = hold_pc_q + 32'd4;
            valid_d      = 1'b1;
            hold_valid_d = 1'b0;
        end else if (resp) begin
            instr_d = imem.imem_rdata;
            pcd_d   = req_pc_q;
            pcp4_d  = req_pc_q + 32'd4;
            valid_d = 1'b1;
        end

        // a redirect makes any buffered (younger) instruction stale
        if (PCSrcE) hold_valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            pcf_q        <= RESET_PC;
            req_pc_q     <= '0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            instr_q      <= NOP_INSTR;
            pcd_q        <= '0;
            pcp4_q       <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            req_pc_q     <= req_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            hold_pc_q    <= hold_pc_d;
            instr_q      <= instr_d;
            pcd_q        <= pcd_d;
            pcp4_q       <= pcp4_d;
            valid_q      <= valid_d;
        end
    end

endmodule
